conc_trace_recorder: RTL

CONC_TRACE_RECORDER -- requirements
Module: conc_trace_recorder

---
 rtl/conc_trace_recorder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conc_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module      : conc_trace_recorder
// Description : Start/stop capture buffer for DUT observations with in-order
//               readout once capture ends. Defining CONC_TRACE_TIMESTAMP_EN
//               prefixes every entry with cycle[15:0] of its write cycle.
// Revision    : 1.0  initial release
// ============================================================================
module conc_trace_recorder #(
    parameter int DEPTH = 16,
    parameter int DW    = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [DW-1:0]            smp_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
`ifdef CONC_TRACE_TIMESTAMP_EN
    output logic [DW+15:0]           rd_data,
`else
    output logic [DW-1:0]            rd_data,
`endif
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              cycle
);

    localparam int AW = $clog2(DEPTH);
`ifdef CONC_TRACE_TIMESTAMP_EN
    localparam int EW = DW + 16;
`else
    localparam int EW = DW;
`endif
    localparam logic [AW:0] C_FULL_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] C_ONE     = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_FULL    = 2'b10,
        S_DRAIN   = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            rd_valid_q, rd_valid_d;
    logic [EW-1:0]   rd_data_q, rd_data_d;
    logic [31:0]     cycle_q;
    logic            wr_en;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   mem_q [DEPTH];

`ifdef CONC_TRACE_TIMESTAMP_EN
    assign wr_entry = {cycle_q[15:0], smp_data};
`else
    assign wr_entry = smp_data;
`endif

    // Capture writes only in CAPTURE, reads only in FULL/DRAIN, so the two
    // memory ports are never active in the same cycle.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (stop) begin
                    state_d = S_DRAIN;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                    if (count_q == C_FULL_M1) begin
                        state_d = S_FULL;
                    end
                end
            end
            default: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    count_d    = count_q - 1'b1;
                    // Leave on the same edge that presents the final entry.
                    if (count_q == C_ONE) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            cycle_q    <= cycle_q + 32'd1;
        end
    end

    // Buffer storage carries no reset; stale entries are unreachable once
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign state    = state_q;
    assign count    = count_q;
    assign cycle    = cycle_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
`default_nettype wire
